// File: rtl/hm10_uart_receiver.sv
// HM-10 receive UART: 8N1 deserialiser, FWFT byte FIFO and idle-gap end-of-message pulse.
// Define HM10_RX_PARITY_EN for 8E1 frames with a sticky parity_error flag.
module hm10_uart_receiver #(
  parameter int FIFO_AW = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         uart_cpd,
  input  logic [9:0]         uart_spacing_limit,
  input  logic               bt_txd,
  input  logic               error_clear,
  input  logic               data_ack,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               msg_end,
  output logic               framing_error,
  output logic               overrun,
  output logic               parity_error
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef HM10_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_nxt;
  logic        sync1, sync2, line_q;
  logic [9:0]  cnt, cnt_nxt, cpd_l, cpd_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shreg, sh_nxt;
  logic        push, set_fe, start_det;
`ifdef HM10_RX_PARITY_EN
  logic        par_bad, pbad_nxt, set_pe;
`endif

  // Counters reload with N-1 so each bit lasts exactly cpd clocks and the
  // first sample lands cpd>>1 clocks after the synchronised falling edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 10'd0) ? cnt - 10'd1 : cnt;
    cpd_nxt   = cpd_l;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    push      = 1'b0;
    set_fe    = 1'b0;
    start_det = 1'b0;
`ifdef HM10_RX_PARITY_EN
    pbad_nxt  = par_bad;
    set_pe    = 1'b0;
`endif
    case (state)
      S_IDLE: if (line_q && !sync2) begin
        start_det = 1'b1;
        cpd_nxt   = uart_cpd;
        cnt_nxt   = (uart_cpd >> 1) - 10'd1;
        state_nxt = S_START;
      end
      S_START: if (cnt == 10'd0) begin
        if (!sync2) begin
          state_nxt = S_DATA;
          cnt_nxt   = cpd_l - 10'd1;
          idx_nxt   = 3'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: if (cnt == 10'd0) begin
        sh_nxt  = {sync2, shreg[7:1]};
        cnt_nxt = cpd_l - 10'd1;
        idx_nxt = bit_idx + 3'd1;
`ifdef HM10_RX_PARITY_EN
        if (bit_idx == 3'd7) state_nxt = S_PARITY;
`else
        if (bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      end
`ifdef HM10_RX_PARITY_EN
      S_PARITY: if (cnt == 10'd0) begin
        pbad_nxt  = ^{shreg, sync2};
        cnt_nxt   = cpd_l - 10'd1;
        state_nxt = S_STOP;
      end
`endif
      S_STOP: if (cnt == 10'd0) begin
        if (sync2) begin
          state_nxt = S_IDLE;
`ifdef HM10_RX_PARITY_EN
          if (par_bad) set_pe = 1'b1;
          else         push   = 1'b1;
`else
          push = 1'b1;
`endif
        end else begin
          set_fe    = 1'b1;
          state_nxt = S_BREAK;
        end
      end
      S_BREAK: if (sync2) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      line_q  <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      cpd_l   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync1   <= bt_txd;
      sync2   <= sync1;
      line_q  <= sync2;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cpd_l   <= cpd_nxt;
      bit_idx <= idx_nxt;
      shreg   <= sh_nxt;
    end
  end

  // FIFO: pointers wrap naturally; occupancy kept in its own counter.
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, pop, wr_en, ovf;

  assign full       = (fifo_count == (FIFO_AW+1)'(DEPTH));
  assign data_valid = (fifo_count != '0);
  assign pop        = data_ack & data_valid;
  assign wr_en      = push & (~full | pop);
  assign ovf        = push & full & ~pop;
  assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (wr_en && !pop)      fifo_count <= fifo_count + (FIFO_AW+1)'(1);
      else if (!wr_en && pop) fifo_count <= fifo_count - (FIFO_AW+1)'(1);
    end
  end

  // Sticky flags: a new error in the same cycle beats error_clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (set_fe)           framing_error <= 1'b1;
      else if (error_clear) framing_error <= 1'b0;
      if (ovf)              overrun <= 1'b1;
      else if (error_clear) overrun <= 1'b0;
    end
  end

`ifdef HM10_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_bad <= pbad_nxt;
      if (set_pe)           parity_error <= 1'b1;
      else if (error_clear) parity_error <= 1'b0;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  // End-of-message: count idle bit periods after the last push.
  logic       armed;
  logic [9:0] div, bits;

  always_ff @(posedge clock) begin
    if (reset) begin
      armed   <= 1'b0;
      div     <= '0;
      bits    <= '0;
      msg_end <= 1'b0;
    end else begin
      msg_end <= 1'b0;
      if (push) begin
        armed <= 1'b1;
        div   <= '0;
        bits  <= '0;
      end else if (start_det || !armed || state != S_IDLE || uart_spacing_limit == 10'd0) begin
        div  <= '0;
        bits <= '0;
      end else if (div >= uart_cpd - 10'd1) begin
        div <= '0;
        if (bits + 10'd1 == uart_spacing_limit) begin
          msg_end <= 1'b1;
          armed   <= 1'b0;
          bits    <= '0;
        end else begin
          bits <= bits + 10'd1;
        end
      end else begin
        div <= div + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_hm10_uart_receiver.sv
// Scoreboard bench for hm10_uart_receiver: expected bytes queued at send, compared on every pop.
module tb_hm10_uart_receiver;
  localparam int AW = 4;
`ifdef HM10_RX_PARITY_EN
  localparam int NB = 10;
  logic flip_par = 1'b0;
`else
  localparam int NB = 9;
`endif

  logic          clock = 1'b0, reset = 1'b1;
  logic [9:0]    uart_cpd = 10'd50, uart_spacing_limit = 10'd0;
  logic          bt_txd = 1'b1, error_clear = 1'b0, data_ack = 1'b0;
  logic [7:0]    data_out;
  logic          data_valid, msg_end, framing_error, overrun, parity_error;
  logic [AW:0]   fifo_count;

  int total = 0, bad = 0, cyc = 0, dv_rise = 0, msg_cnt = 0, msg_cyc = 0;
  int cpd = 50;
  logic dv_q = 1'b0;
  logic [7:0] sb [$];

  hm10_uart_receiver #(.FIFO_AW(AW)) dut (
    .clock(clock), .reset(reset), .uart_cpd(uart_cpd), .uart_spacing_limit(uart_spacing_limit),
    .bt_txd(bt_txd), .error_clear(error_clear), .data_ack(data_ack), .data_out(data_out),
    .data_valid(data_valid), .fifo_count(fifo_count), .msg_end(msg_end),
    .framing_error(framing_error), .overrun(overrun), .parity_error(parity_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observes every pop, data_valid rise and msg_end pulse.
  always @(negedge clock) begin
    if (data_valid && !dv_q) dv_rise = cyc;
    dv_q = data_valid;
    if (msg_end) begin
      msg_cnt++;
      msg_cyc = cyc;
    end
    if (data_valid && data_ack) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
      else                chk("pop_data", 32'(data_out), 32'(sb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bt_txd = 1'b0;
    tick(cpd);
    for (int i = 0; i < 8; i++) begin
      bt_txd = b[i];
      tick(cpd);
    end
`ifdef HM10_RX_PARITY_EN
    bt_txd = (^b) ^ flip_par;
    tick(cpd);
`endif
    bt_txd = stop;
    tick(cpd);
    bt_txd = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while (data_valid && g < 64) begin
      data_ack = 1'b1;
      tick(1);
      g++;
    end
    data_ack = 1'b0;
    @(negedge clock);
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_sb_left", 32'(sb.size()), 0);
    tick(1);
  endtask

  task automatic pulse_clear();
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end

  initial begin
    int c0, m0, d, e;
    tick(3);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_msg", 32'(msg_end), 0);
    chk("rst_fe", 32'(framing_error), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_pe", 32'(parity_error), 0);
    tick(1);

    // single byte latency and ack
    c0 = cyc;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    @(negedge clock);
    chk("a5_latency", 32'(dv_rise - c0), 32'(3 + cpd / 2 + NB * cpd));
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_count", 32'(fifo_count), 1);
    tick(1);
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
    @(negedge clock);
    chk("ack_count", 32'(fifo_count), 0);
    chk("ack_valid", 32'(data_valid), 0);
    tick(1);

    // one-clock glitches are false starts
    for (int i = 0; i < 10; i++) begin
      bt_txd = 1'b0;
      tick(1);
      bt_txd = 1'b1;
      tick(40);
    end
    tick(60);
    @(negedge clock);
    chk("glitch_count", 32'(fifo_count), 0);
    chk("glitch_fe", 32'(framing_error), 0);
    chk("glitch_ovr", 32'(overrun), 0);
    tick(1);

    // framing error, recovery, clear
    send_byte(8'h3C, 1'b0);
    @(negedge clock);
    chk("fe_set", 32'(framing_error), 1);
    chk("fe_count", 32'(fifo_count), 0);
    tick(cpd);
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    drain();
    pulse_clear();
    @(negedge clock);
    chk("fe_cleared", 32'(framing_error), 0);
    tick(1);

    // 17 back-to-back bytes into a 16-deep FIFO
    for (int i = 0; i < 16; i++) sb.push_back(8'(i));
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    @(negedge clock);
    chk("full_count", 32'(fifo_count), 16);
    chk("ovr_set", 32'(overrun), 1);
    tick(1);
    drain();
    pulse_clear();
    @(negedge clock);
    chk("ovr_cleared", 32'(overrun), 0);
    tick(1);

    // same again, with a pop in the very cycle of the 17th push
    for (int i = 0; i < 17; i++) sb.push_back(8'(i));
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    fork
      send_byte(8'h10, 1'b1);
      begin
        repeat (2 + cpd / 2 + NB * cpd) @(posedge clock);
        #1 data_ack = 1'b1;
        @(posedge clock);
        #1 data_ack = 1'b0;
      end
    join
    @(negedge clock);
    chk("pushpop_count", 32'(fifo_count), 16);
    chk("pushpop_ovr", 32'(overrun), 0);
    tick(1);
    drain();

    // end-of-message after 3 idle bit periods
    uart_spacing_limit = 10'd3;
    m0 = msg_cnt;
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    send_byte(8'h41, 1'b1);
    c0 = cyc;
    send_byte(8'h42, 1'b1);
    tick(300);
    @(negedge clock);
    chk("msg_pulses", 32'(msg_cnt - m0), 1);
    d = msg_cyc - c0;
    e = 3 + cpd / 2 + NB * cpd + 3 * cpd;
    chk("msg_in_window", 32'(d >= e - 1 && d <= e + 1), 1);
    tick(1);
    drain();
    uart_spacing_limit = 10'd0;
    m0 = msg_cnt;
    sb.push_back(8'h43);
    send_byte(8'h43, 1'b1);
    tick(300);
    @(negedge clock);
    chk("msg_disabled", 32'(msg_cnt - m0), 0);
    tick(1);
    drain();

    // reset in the middle of a data bit
    sb.push_back(8'h77);
    send_byte(8'h77, 1'b1);
    send_byte(8'h3C, 1'b0);
    @(negedge clock);
    chk("pre_rst_count", 32'(fifo_count), 1);
    chk("pre_rst_fe", 32'(framing_error), 1);
    tick(cpd);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (12 + cpd / 2 + 5 * cpd) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        sb.delete();
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_data", 32'(data_out), 0);
        chk("mid_rst_fe", 32'(framing_error), 0);
        chk("mid_rst_msg", 32'(msg_end), 0);
      end
    join
    tick(cpd);
    sb.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    @(negedge clock);
    chk("post_rst_count", 32'(fifo_count), 1);
    tick(1);
    drain();

`ifdef HM10_RX_PARITY_EN
    flip_par = 1'b1;
    send_byte(8'h07, 1'b1);
    @(negedge clock);
    chk("par_set", 32'(parity_error), 1);
    chk("par_count", 32'(fifo_count), 0);
    tick(1);
    flip_par = 1'b0;
    sb.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    drain();
    pulse_clear();
    flip_par = 1'b1;
    send_byte(8'h07, 1'b0);
    @(negedge clock);
    chk("par_fe_wins_fe", 32'(framing_error), 1);
    chk("par_fe_wins_pe", 32'(parity_error), 0);
    tick(cpd);
    flip_par = 1'b0;
`else
    @(negedge clock);
    chk("par_tied", 32'(parity_error), 0);
    tick(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
